// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM
// state encoding and store byte-lane masks.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H_LO = 4'b0011;
  localparam logic [3:0] MASK_H_HI = 4'b1100;
  localparam logic [3:0] MASK_W    = 4'b1111;

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Picks the addressed byte/halfword out of a memory word and sign- or
// zero-extends it according to the load width code.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    byte_sel = rdata[7:0];
    case (byte_off)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'b0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'b0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a core request port and a
// word-wide data memory with byte write enables and registered read data.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int HEIGHT = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  output logic [3:0]  o_mem_wen,
  output logic        o_mem_ren,
  input  logic [31:0] i_mem_rd
);

  localparam logic [32:0] ADDR_LIMIT = 33'(HEIGHT) * 33'd4;

  lsu_state_e  state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        err_q;
  logic [3:0]  mask_q;
  logic        req_err;
  logic [3:0]  req_mask;
  logic [31:0] req_wd;
  logic [31:0] load_data;
  logic        accept;

  assign accept = (state_q == ST_IDLE) && i_req_valid;

  // Decode the incoming request: error, byte mask and lane-replicated data.
  always_comb begin
    req_err  = 1'b0;
    req_mask = MASK_NONE;
    req_wd   = i_req_wdata;
    case (i_req_funct3)
      F3_B: begin
        req_mask = MASK_B << i_req_addr[1:0];
        req_wd   = {4{i_req_wdata[7:0]}};
      end
      F3_H: begin
        req_mask = i_req_addr[1] ? MASK_H_HI : MASK_H_LO;
        req_wd   = {2{i_req_wdata[15:0]}};
        req_err  = i_req_addr[0];
      end
      F3_W: begin
        req_mask = MASK_W;
        req_err  = |i_req_addr[1:0];
      end
      F3_BU:   req_err = i_req_we;
      F3_HU:   req_err = i_req_we | i_req_addr[0];
      default: req_err = 1'b1;
    endcase
    if ({1'b0, i_req_addr} >= ADDR_LIMIT) req_err = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_rsp_err   = 1'b0;
    o_mem_wen   = MASK_NONE;
    o_mem_ren   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_d = req_err ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (we_q) begin
          o_mem_wen = mask_q;
          state_d   = ST_RESP;
        end else begin
          o_mem_ren = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: state_d = ST_RESP;
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_err   = err_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  load_extend u_load_extend (
    .funct3   (funct3_q),
    .byte_off (off_q),
    .rdata    (i_mem_rd),
    .data     (load_data)
  );

  always_ff @(posedge i_clk) begin
    // NOTE: datapath registers are reset as well because their reset values are visible on the ports.
    if (!i_rst_n) begin
      we_q        <= 1'b0;
      funct3_q    <= F3_B;
      off_q       <= 2'd0;
      err_q       <= 1'b0;
      mask_q      <= MASK_NONE;
      o_mem_addr  <= '0;
      o_mem_wd    <= '0;
      o_rsp_rdata <= '0;
    end else begin
      if (accept) begin
        we_q        <= i_req_we;
        funct3_q    <= i_req_funct3;
        off_q       <= i_req_addr[1:0];
        err_q       <= req_err;
        mask_q      <= req_mask;
        o_rsp_rdata <= '0;
        if (!req_err) begin
          o_mem_addr <= {2'b00, i_req_addr[31:2]};
          if (i_req_we) o_mem_wd <= req_wd;
        end
      end
      if (state_q == ST_WAIT) o_rsp_rdata <= load_data;
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter HEIGHT, default 256, memory depth in 32-bit words; byte addresses >= HEIGHT*4 are out of range.
REQ-002 SHALL have ports: i_clk  in  1  rising-edge clock, the only clock.
REQ-003 i_rst_n  in  1  reset, synchronous, active-low.
REQ-004 i_req_valid  in  1  core request present; o_req_ready  out  1  unit accepts a request this cycle.
REQ-005 i_req_we  in  1  1=store, 0=load; i_req_funct3  in  3  RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 i_req_addr  in  32  byte address; i_req_wdata  in  32  store data, right-aligned.
REQ-007 o_rsp_valid  out  1  one-cycle completion pulse; o_rsp_rdata  out  32  extended load data; o_rsp_err  out  1  misaligned, out-of-range or illegal funct3.
REQ-008 o_mem_addr  out  32  word address to the data memory; o_mem_wd  out  32  lane-aligned write data; o_mem_wen  out  4  byte write mask (bit n = byte lane n); o_mem_ren  out  1  read strobe; i_mem_rd  in  32  registered memory read data, valid the cycle after o_mem_ren.

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP; o_req_ready SHALL be 1 only in IDLE.
REQ-010 In IDLE with i_req_valid=1, the request SHALL be latched; a legal store or load SHALL go to ACCESS, an erroring request SHALL go directly to RESP with no memory strobe.
REQ-011 Error SHALL be: H/HU with addr[0]=1; W with addr[1:0]!=0; addr >= HEIGHT*4; funct3 in {011,110,111}; store with funct3 in {100,101}.
REQ-012 In ACCESS, o_mem_addr SHALL equal latched addr[31:2]; store SHALL drive o_mem_wen, load SHALL drive o_mem_ren=1 with o_mem_wen=0000; never both.
REQ-013 Store masks: B -> 0001<<addr[1:0]; H -> 0011 (addr[1]=0) or 1100 (addr[1]=1); W -> 1111.
REQ-014 o_mem_wd SHALL be wdata replicated to all lanes for B/H (byte x4, halfword x2), wdata unchanged for W.
REQ-015 Store: ACCESS -> RESP; o_rsp_valid at cycle 2 after acceptance (acceptance = cycle 0), o_rsp_rdata=0.
REQ-016 Load: ACCESS -> WAIT -> RESP; in WAIT i_mem_rd SHALL be lane-selected by addr[1:0] and sign-extended (B, H) or zero-extended (BU, HU, W not extended) and registered; o_rsp_valid at cycle 3.
REQ-017 RESP SHALL assert o_rsp_valid=1 for exactly one cycle with o_rsp_err per REQ-011, then return to IDLE; no response backpressure.
REQ-018 All memory strobes SHALL be 0 in every state except ACCESS; o_mem_addr/o_mem_wd hold last value when idle.
REQ-019 Back-to-back: a new request SHALL be accepted in the cycle after RESP (IDLE), giving 3-cycle store and 4-cycle load throughput.
REQ-020 i_req_* SHALL be ignored outside IDLE; changes mid-operation SHALL not affect the in-flight access.

Reset
REQ-021 On a rising edge with i_rst_n=0: state=IDLE, o_req_ready=1, o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0, o_mem_wen=0000, o_mem_ren=0, o_mem_addr=0, o_mem_wd=0.
REQ-022 Reset mid-operation SHALL abort without response; a memory write strobed before the reset edge is sampled by memory on that edge and completes.

Structure
REQ-023 Shared package SHALL hold funct3 width-code constants, FSM state encoding (2 bits) and the byte-mask constants.
REQ-024 One combinational sub-module load_extend (lane select + sign/zero extension) SHALL be used in WAIT; mask/replication logic stays in the top.

Verification
REQ-025 SB addr=0x0000_0006 wdata=0x0000_00A5 -> ACCESS: o_mem_addr=1, o_mem_wen=0100, o_mem_wd=0xA5A5_A5A5; o_rsp_valid cycle 2, err=0.
REQ-026 LB addr=0x0000_0007, i_mem_rd=0x80FF_0000 -> o_rsp_rdata=0xFFFF_FF80; LBU same -> 0x0000_0080; o_rsp_valid cycle 3.
REQ-027 LH addr=0x0000_0002, i_mem_rd=0x8001_1234 -> 0xFFFF_8001; LW addr=0x0000_0004, i_mem_rd=0xDEAD_BEEF -> 0xDEAD_BEEF.
REQ-028 SW addr=0x0000_0002; LH addr=0x0000_0401 (HEIGHT=256); SB funct3=100 -> each: no strobe ever, o_rsp_valid=1 with o_rsp_err=1 at cycle 1.
REQ-029 SH addr=0x0000_0002 wdata=0x1234 -> o_mem_wen=1100, o_mem_wd=0x1234_1234; immediately followed by LW -> accepted one cycle after RESP, o_mem_ren=1 and o_mem_wen=0000 in its ACCESS.
REQ-030 i_rst_n=0 during load WAIT -> next edge all outputs per REQ-021, no o_rsp_valid; next request accepted normally after release.
